cpu_irq_sequencer: RTL and testbench
====================================

Name: cpu_irq_sequencer

Overview:
Sequences interrupt entry into, and MRET exit from, the 5-stage pipeline CPU.
- Entry: picks the highest-priority pending enabled interrupt, waits for an Execute-stage instruction that is safe to squash, then flushes F/D/E, redirects the PC to the vector and saves the return PC.
- Exit: on MRET in Execute, flushes and redirects to the saved PC.
- Sits beside the hazard unit. Its flush/PC-load outputs are ORed into the pipeline flush and PC-select logic at the top level.

Parameters:
NUM_IRQ, 8, number of interrupt lines (1..32); index 0 = highest priority.
PC_W, 32, PC / address width.
VEC_BASE, 32'h0000_0100, vector for IRQ i = VEC_BASE + 4*i (truncated to PC_W).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
irq_req  in  NUM_IRQ  level-sensitive interrupt requests
irq_en  in  NUM_IRQ  per-line enable mask
glb_irq_en  in  1  global interrupt enable
e_valid  in  1  Execute stage holds a valid (non-bubble) instruction
e_pc  in  PC_W  PC of the instruction in Execute
e_is_mret  in  1  Execute instruction is MRET
pc_src  in  1  branch/jump taken, resolved in Execute
hzd_stall  in  1  load-hazard stall active (hazard unit f_stall)
irq_flush  out  1  flush Decode and Execute, discard Fetch
irq_pc_load  out  1  load PC with irq_pc_val this cycle
irq_pc_val  out  PC_W  redirect target
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken IRQ
irq_active  out  1  ISR in progress (nesting blocked)
irq_id  out  5  index of the IRQ being serviced
epc  out  PC_W  saved return PC

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high.
- Reset values: state=IDLE; irq_flush=0, irq_pc_load=0, irq_pc_val=0, irq_ack=0, irq_active=0, irq_id=0, epc=0.
- Derived signals:
  - pending = irq_req & irq_en
  - sel = lowest set index of pending (fixed priority)
  - safe = e_valid & ~pc_src & ~hzd_stall
- FSM states: IDLE, WAIT_SAFE, IN_ISR.
- IDLE:
  - If glb_irq_en & |pending: register irq_id<=sel and go to WAIT_SAFE.
  - Otherwise stay.
  - MRET seen in IDLE is ignored: no flush, no redirect.
- WAIT_SAFE, abort check first:
  - If irq_req[irq_id]==0, irq_en[irq_id]==0 or glb_irq_en==0: spurious request; return to IDLE with no outputs asserted.
  - irq_id is frozen while in WAIT_SAFE. A higher-priority request arriving now does not preempt it.
- WAIT_SAFE, when safe=1 (Mealy, same cycle):
  - irq_flush=1, irq_pc_load=1, irq_pc_val=VEC_BASE+(irq_id<<2), irq_ack[irq_id]=1.
  - epc<=e_pc. The squashed Execute instruction re-executes after return.
  - Next state IN_ISR.
- WAIT_SAFE, when safe=0: hold, no outputs.
  - A taken branch never gets interrupted in its resolving cycle.
  - A load-stall bubble is never chosen as the return point.
- IN_ISR:
  - irq_active=1; new requests are ignored.
  - When e_valid & e_is_mret & ~hzd_stall (Mealy): irq_flush=1, irq_pc_load=1, irq_pc_val=epc; next state IDLE.
  - irq_active drops the following cycle. A pending IRQ can then be latched in IDLE on that cycle at the earliest.
- Latency: IRQ rising at cycle N, with safe held at 1, gives flush/redirect/ack at N+1 and irq_active=1 at N+2.
- Output pulses: irq_ack, irq_flush and irq_pc_load are single-cycle per event and never asserted in IDLE.
- Reset mid-operation: a reset asserted in any state returns to IDLE with all outputs and epc cleared on the next edge.
- Width rules: vector arithmetic is mod 2^PC_W. irq_id is zero-extended to 5 bits.

Test Plan:
1. Basic entry: VEC_BASE=0x100, irq_req=0x08, irq_en=0xFF, glb=1, e_valid=1, e_pc=0x40. Expect at N+1: irq_pc_val=0x10C, irq_ack=0x08, irq_flush=1; epc=0x40; irq_active=1 at N+2.
2. Priority plus unsafe wait: irq_req=0x0A with pc_src=1 for 2 cycles, then hzd_stall=1 for 1 cycle. Expect irq_id=1, no flush while unsafe, flush/ack=0x02/vector 0x104 in the first safe cycle.
3. Spurious abort: irq_req[2] pulses for 1 cycle while e_valid=0. Expect WAIT_SAFE→IDLE, no ack/flush/pc_load, epc unchanged.
4. Return: in IN_ISR with epc=0x40, assert e_is_mret & e_valid. Expect same-cycle irq_pc_load=1, irq_pc_val=0x40, irq_flush=1; irq_active=0 next cycle. MRET with hzd_stall=1 is deferred until the stall clears.
5. No nesting plus back-to-back: raise irq_req[0] during ISR. Expect no ack until MRET; ack=0x01 at the earliest two cycles after the MRET cycle. MRET issued in IDLE produces no redirect.
6. Reset mid-ISR: assert rst for 1 cycle in IN_ISR. Expect state IDLE, irq_active=0, epc=0, all pulses 0 the following cycle.

Source files
------------

// File: rtl/cpu_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_irq_sequencer
// Description : Interrupt entry and MRET exit sequencing for the 5-stage CPU.
//               Selects a fixed-priority IRQ, waits for a squashable Execute
//               instruction, then flushes and redirects to the vector.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_irq_sequencer #(
    parameter int                NUM_IRQ  = 8,
    parameter int                PC_W     = 32,
    parameter logic [PC_W-1:0]   VEC_BASE = PC_W'(32'h0000_0100)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_req,
    input  logic [NUM_IRQ-1:0]   irq_en,
    input  logic                 glb_irq_en,
    input  logic                 e_valid,
    input  logic [PC_W-1:0]      e_pc,
    input  logic                 e_is_mret,
    input  logic                 pc_src,
    input  logic                 hzd_stall,
    output logic                 irq_flush,
    output logic                 irq_pc_load,
    output logic [PC_W-1:0]      irq_pc_val,
    output logic [NUM_IRQ-1:0]   irq_ack,
    output logic                 irq_active,
    output logic [4:0]           irq_id,
    output logic [PC_W-1:0]      epc
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_SAFE = 2'd1;
    localparam logic [1:0] S_IN_ISR    = 2'd2;

    logic [1:0]          r_state_q,      w_state_d;
    logic [4:0]          r_irq_id_q,     w_irq_id_d;
    logic [PC_W-1:0]     r_epc_q,        w_epc_d;
    logic                r_irq_active_q, w_irq_active_d;

    logic [NUM_IRQ-1:0]  w_pending;
    logic [NUM_IRQ-1:0]  w_id_onehot;
    logic [4:0]          w_sel;
    logic                w_safe;
    logic                w_cur_ok;
    logic                w_mret_go;

    // Fixed priority: the lowest pending index wins.
    always_comb begin
        w_pending = irq_req & irq_en;
        w_sel     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_sel = 5'(i);
            end
        end
        w_id_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_id_onehot[i] = (r_irq_id_q == 5'(i));
        end
    end

    assign w_safe    = e_valid & ~pc_src & ~hzd_stall;
    assign w_cur_ok  = glb_irq_en & (|(w_id_onehot & w_pending));
    assign w_mret_go = e_valid & e_is_mret & ~hzd_stall;

    always_comb begin
        w_state_d      = r_state_q;
        w_irq_id_d     = r_irq_id_q;
        w_epc_d        = r_epc_q;
        w_irq_active_d = r_irq_active_q;
        irq_flush      = 1'b0;
        irq_pc_load    = 1'b0;
        irq_pc_val     = '0;
        irq_ack        = '0;
        case (r_state_q)
            S_IDLE: begin
                if (glb_irq_en && (|w_pending)) begin
                    w_irq_id_d = w_sel;
                    w_state_d  = S_WAIT_SAFE;
                end
            end
            S_WAIT_SAFE: begin
                // A request that vanished before entry is dropped silently.
                if (!w_cur_ok) begin
                    w_state_d = S_IDLE;
                end else if (w_safe) begin
                    irq_flush      = 1'b1;
                    irq_pc_load    = 1'b1;
                    irq_pc_val     = VEC_BASE + PC_W'({r_irq_id_q, 2'b00});
                    irq_ack        = w_id_onehot;
                    w_epc_d        = e_pc;
                    w_irq_active_d = 1'b1;
                    w_state_d      = S_IN_ISR;
                end
            end
            S_IN_ISR: begin
                if (w_mret_go) begin
                    irq_flush      = 1'b1;
                    irq_pc_load    = 1'b1;
                    irq_pc_val     = r_epc_q;
                    w_irq_active_d = 1'b0;
                    w_state_d      = S_IDLE;
                end
            end
            default: begin
                w_irq_active_d = 1'b0;
                w_state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_irq_id_q     <= '0;
            r_epc_q        <= '0;
            r_irq_active_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_irq_id_q     <= w_irq_id_d;
            r_epc_q        <= w_epc_d;
            r_irq_active_q <= w_irq_active_d;
        end
    end

    assign irq_active = r_irq_active_q;
    assign irq_id     = r_irq_id_q;
    assign epc        = r_epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_irq_sequencer
// Description : Scoreboard bench for cpu_irq_sequencer with a behavioural
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_irq_sequencer;

    localparam int          NUM_IRQ  = 8;
    localparam int          PC_W     = 32;
    localparam logic [31:0] VEC_BASE = 32'h0000_0100;

    logic                clk;
    logic                rst;
    logic [NUM_IRQ-1:0]  irq_req;
    logic [NUM_IRQ-1:0]  irq_en;
    logic                glb_irq_en;
    logic                e_valid;
    logic [PC_W-1:0]     e_pc;
    logic                e_is_mret;
    logic                pc_src;
    logic                hzd_stall;
    logic                irq_flush;
    logic                irq_pc_load;
    logic [PC_W-1:0]     irq_pc_val;
    logic [NUM_IRQ-1:0]  irq_ack;
    logic                irq_active;
    logic [4:0]          irq_id;
    logic [PC_W-1:0]     epc;

    cpu_irq_sequencer #(
        .NUM_IRQ  (NUM_IRQ),
        .PC_W     (PC_W),
        .VEC_BASE (VEC_BASE)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .irq_req     (irq_req),
        .irq_en      (irq_en),
        .glb_irq_en  (glb_irq_en),
        .e_valid     (e_valid),
        .e_pc        (e_pc),
        .e_is_mret   (e_is_mret),
        .pc_src      (pc_src),
        .hzd_stall   (hzd_stall),
        .irq_flush   (irq_flush),
        .irq_pc_load (irq_pc_load),
        .irq_pc_val  (irq_pc_val),
        .irq_ack     (irq_ack),
        .irq_active  (irq_active),
        .irq_id      (irq_id),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected redirect event: cycle it must appear in, target and ack.
    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [7:0]  ack;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          chk_en = 1'b0;

    // Reference model: "an interrupt has been chosen", "ISR running".
    bit          m_claimed = 1'b0;
    bit          m_in_isr  = 1'b0;
    int          m_id      = 0;
    logic [31:0] m_epc     = '0;
    bit          exp_active_now = 1'b0;
    logic [31:0] exp_epc_now    = '0;
    logic [4:0]  exp_id_now     = '0;

    logic [7:0]  s_req;
    logic [7:0]  s_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] pend;
        ev_t        ev;
        exp_active_now = m_in_isr;
        exp_epc_now    = m_epc;
        exp_id_now     = 5'(m_id);
        pend = irq_req & irq_en;
        if (m_in_isr) begin
            if (e_valid && e_is_mret && !hzd_stall) begin
                ev.cyc = cyc; ev.pc = m_epc; ev.ack = 8'h00;
                exp_q.push_back(ev);
                m_in_isr = 1'b0;
            end
        end else if (m_claimed) begin
            if (!(irq_req[m_id] && irq_en[m_id] && glb_irq_en)) begin
                m_claimed = 1'b0;
            end else if (e_valid && !pc_src && !hzd_stall) begin
                ev.cyc = cyc; ev.pc = VEC_BASE + 32'(4 * m_id); ev.ack = 8'(1 << m_id);
                exp_q.push_back(ev);
                m_epc     = e_pc;
                m_in_isr  = 1'b1;
                m_claimed = 1'b0;
            end
        end else if (glb_irq_en && pend != 8'h00) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (pend[i]) m_id = i;
            end
            m_claimed = 1'b1;
        end
        if (rst) begin
            m_claimed = 1'b0;
            m_in_isr  = 1'b0;
            m_id      = 0;
            m_epc     = '0;
        end
    endtask

    task automatic drive(input logic [7:0] req, input logic [7:0] en, input bit g,
                         input bit v, input logic [31:0] pc, input bit mret,
                         input bit ps, input bit st, input bit r);
        @(posedge clk);
        #1;
        cyc++;
        irq_req = req; irq_en = en; glb_irq_en = g; e_valid = v; e_pc = pc;
        e_is_mret = mret; pc_src = ps; hzd_stall = st; rst = r;
        model_step();
    endtask

    // Monitor: pops an expected event whenever the DUT redirects.
    always @(negedge clk) begin
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                errors++;
                checks++;
                $display("FAIL missed_event: got none expected pc %h in cycle %0d", exp_q[0].pc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (irq_pc_load || irq_flush || (irq_ack != 8'h00)) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_event (cycle %0d): got pc_load=%b flush=%b pc %h ack %h expected no event",
                             cyc, irq_pc_load, irq_flush, irq_pc_val, irq_ack);
                end else begin
                    chk("flush", 32'(irq_flush), 32'd1);
                    chk("pc_load", 32'(irq_pc_load), 32'd1);
                    chk("pc_val", irq_pc_val, exp_q[0].pc);
                    chk("ack", 32'(irq_ack), 32'(exp_q[0].ack));
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                errors++;
                checks++;
                $display("FAIL missed_event: got none expected pc %h in cycle %0d", exp_q[0].pc, cyc);
                void'(exp_q.pop_front());
            end
            chk("irq_active", 32'(irq_active), 32'(exp_active_now));
            chk("epc", epc, exp_epc_now);
            chk("irq_id", 32'(irq_id), 32'(exp_id_now));
        end
    end

    initial begin
        irq_req = '0; irq_en = '0; glb_irq_en = 1'b0; e_valid = 1'b0; e_pc = '0;
        e_is_mret = 1'b0; pc_src = 1'b0; hzd_stall = 1'b0; rst = 1'b1;
        drive(8'h00, 8'h00, 0, 0, 32'h0, 0, 0, 0, 1);
        drive(8'h00, 8'h00, 0, 0, 32'h0, 0, 0, 0, 1);
        chk_en = 1'b1;
        drive(8'h00, 8'hFF, 1, 1, 32'h0, 0, 0, 0, 0);

        // Basic entry to IRQ3, then a stalled MRET followed by a real one.
        drive(8'h08, 8'hFF, 1, 1, 32'h40, 0, 0, 0, 0);
        drive(8'h08, 8'hFF, 1, 1, 32'h40, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h44, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h48, 1, 0, 1, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h48, 1, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h40, 0, 0, 0, 0);

        // Priority with branch and stall delaying entry.
        drive(8'h0A, 8'hFF, 1, 1, 32'h80, 0, 0, 0, 0);
        drive(8'h0A, 8'hFF, 1, 1, 32'h80, 0, 1, 0, 0);
        drive(8'h0B, 8'hFF, 1, 1, 32'h84, 0, 1, 0, 0);
        drive(8'h0A, 8'hFF, 1, 1, 32'h88, 0, 0, 1, 0);
        drive(8'h0A, 8'hFF, 1, 1, 32'h88, 0, 0, 0, 0);

        // Higher-priority request during the ISR, then back-to-back entry.
        drive(8'h01, 8'hFF, 1, 1, 32'h104, 0, 0, 0, 0);
        drive(8'h01, 8'hFF, 1, 1, 32'h108, 1, 0, 0, 0);
        drive(8'h01, 8'hFF, 1, 1, 32'h88, 0, 0, 0, 0);
        drive(8'h01, 8'hFF, 1, 1, 32'h8C, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h100, 1, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h8C, 1, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h90, 0, 0, 0, 0);

        // Spurious one-cycle pulse while Execute is empty.
        drive(8'h04, 8'hFF, 1, 0, 32'h90, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 0, 32'h90, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h94, 0, 0, 0, 0);

        // Reset in the middle of an ISR.
        drive(8'h80, 8'hFF, 1, 1, 32'h200, 0, 0, 0, 0);
        drive(8'h80, 8'hFF, 1, 1, 32'h200, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h11C, 0, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h120, 0, 0, 0, 1);
        drive(8'h00, 8'hFF, 1, 1, 32'h0, 1, 0, 0, 0);
        drive(8'h00, 8'hFF, 1, 1, 32'h4, 0, 0, 0, 0);

        s_req = 8'h00;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) s_req = 8'($urandom) & 8'($urandom);
            s_en = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            drive(s_req, s_en, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
                  32'($urandom) & 32'hFFFF_FFFC, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 499) == 0);
        end

        for (int k = 0; k < 4; k++) begin
            drive(8'h00, 8'hFF, 1, 1, 32'h0, 0, 0, 0, 0);
        end
        @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got none expected pc %h in cycle %0d", exp_q[0].pc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
